// File: rtl/mem_port_arbiter.sv
// Shares one memory/MMIO port between the IFU and LSU: one transaction in flight, registered responses, watchdog.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN alternates grants when both requesters are pending.
module mem_port_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hdeadbeef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  input  logic [1:0]  lsu_size,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [1:0]  mem_size,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_lsu;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_mem_addr;
  logic              r_mem_wen;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_wmask;
  logic [1:0]        r_mem_size;
  logic [31:0]       r_ifu_rdata;
  logic [31:0]       r_lsu_rdata;
  logic              w_any_req;
  logic              w_grant_lsu;
  logic              w_timeout;

  assign w_any_req = ifu_reqValid | lsu_reqValid;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_rr = 1 means the IFU is preferred at the next contested grant
  logic r_rr;

  assign w_grant_lsu = lsu_reqValid & (~ifu_reqValid | ~r_rr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_rr <= w_grant_lsu;
    end
  end
`else
  assign w_grant_lsu = lsu_reqValid;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: if (mem_respValid || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner_lsu <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_mem_size  <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_lsu <= w_grant_lsu;
            if (w_grant_lsu) begin
              r_mem_addr  <= lsu_addr;
              r_mem_wen   <= lsu_wen;
              r_mem_wdata <= lsu_wdata;
              r_mem_wmask <= lsu_wmask;
              r_mem_size  <= lsu_size;
            end else begin
              r_mem_addr  <= ifu_addr;
              r_mem_wen   <= 1'b0;
              r_mem_wdata <= '0;
              r_mem_wmask <= 4'hf;
              r_mem_size  <= 2'd2;
            end
          end
        end
        S_ISSUE: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          // A real completion beats a same-cycle timeout
          if (mem_respValid) begin
            r_err <= 1'b0;
            if (r_owner_lsu) r_lsu_rdata <= mem_rdata;
            else             r_ifu_rdata <= mem_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_owner_lsu) r_lsu_rdata <= ERR_RDATA;
            else             r_ifu_rdata <= ERR_RDATA;
          end
        end
        S_RESP: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    mem_reqValid  = (r_state == S_ISSUE);
    ifu_respValid = (r_state == S_RESP) & ~r_owner_lsu;
    lsu_respValid = (r_state == S_RESP) &  r_owner_lsu;
    err           = (r_state == S_RESP) &  r_err;
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wen   = r_mem_wen;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign mem_size  = r_mem_size;
  assign ifu_rdata = r_ifu_rdata;
  assign lsu_rdata = r_lsu_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of grants, latencies and timeouts.
// Honours MEM_ARB_ROUND_ROBIN_EN when the build defines it.
module tb_mem_port_arbiter;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hdeadbeef;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic [1:0]  lsu_size = '0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  mem_size;
  logic        mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  bit          m_rr   = 1'b0;
  logic [31:0] m_ifu_rd = '0;
  logic [31:0] m_lsu_rd = '0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_size(lsu_size),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_size(mem_size),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check_eq({tag, "_mreq"}, 32'(mem_reqValid), 32'd0);
    check_eq({tag, "_pulse"}, {29'd0, ifu_respValid, lsu_respValid, err}, 32'd0);
    check_eq({tag, "_ifu_rd"}, ifu_rdata, m_ifu_rd);
    check_eq({tag, "_lsu_rd"}, lsu_rdata, m_lsu_rd);
  endtask

  task automatic rand_lsu();
    lsu_addr  = $urandom;
    lsu_wen   = 1'($urandom);
    lsu_wdata = $urandom;
    lsu_wmask = 4'($urandom);
    lsu_size  = 2'($urandom_range(2, 0));
  endtask

  // Starts in an IDLE cycle with at least one request raised; ends in the following IDLE cycle.
  task automatic run_txn(input int lat, input logic [31:0] word, output bit obs_lsu);
    bit          win_lsu;
    bit          to;
    int          n_issue;
    logic [31:0] ea, ed, exp_rd;
    logic        ew;
    logic [3:0]  em;
    logic [1:0]  es;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    win_lsu = lsu_reqValid && (!ifu_reqValid || !m_rr);
    m_rr    = win_lsu;
`else
    win_lsu = lsu_reqValid;
`endif
    if (win_lsu) begin
      ea = lsu_addr; ew = lsu_wen; ed = lsu_wdata; em = lsu_wmask; es = lsu_size;
    end else begin
      ea = ifu_addr; ew = 1'b0; ed = '0; em = 4'hf; es = 2'd2;
    end
    to      = (lat >= TO);
    n_issue = to ? TO : lat + 1;
    for (int i = 0; i < n_issue; i++) begin
      tick();
      mem_respValid = (i == lat);
      mem_rdata     = (i == lat) ? word : $urandom;
      check_eq("issue_mreq", 32'(mem_reqValid), 32'd1);
      check_eq("issue_addr", mem_addr, ea);
      check_eq("issue_ctl", {25'd0, mem_wen, mem_wmask, mem_size}, {25'd0, ew, em, es});
      if (win_lsu) check_eq("issue_wdata", mem_wdata, ed);
      check_eq("issue_pulse", {29'd0, ifu_respValid, lsu_respValid, err}, 32'd0);
    end
    tick();
    mem_respValid = 1'($urandom);
    mem_rdata     = $urandom;
    exp_rd = to ? ERR : word;
    if (win_lsu) m_lsu_rd = exp_rd;
    else         m_ifu_rd = exp_rd;
    check_eq("resp_ifu", 32'(ifu_respValid), 32'(!win_lsu));
    check_eq("resp_lsu", 32'(lsu_respValid), 32'(win_lsu));
    check_eq("resp_err", 32'(err), 32'(to));
    check_eq("resp_mreq", 32'(mem_reqValid), 32'd0);
    check_eq("resp_ifu_rd", ifu_rdata, m_ifu_rd);
    check_eq("resp_lsu_rd", lsu_rdata, m_lsu_rd);
    obs_lsu = lsu_respValid;
    tick();
    mem_respValid = 1'($urandom);
    check_idle_outs("post");
    if (win_lsu) lsu_reqValid = 1'b0;
    else         ifu_reqValid = 1'b0;
  endtask

  task automatic idle_cycle();
    mem_respValid = 1'($urandom);
    mem_rdata     = $urandom;
    tick();
    check_idle_outs("idle");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    mem_respValid = 1'b0;
    m_rr = 1'b0; m_ifu_rd = '0; m_lsu_rd = '0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    bit obs;
    bit exp_lsu;
    // Reset state
    tick(); tick();
    check_eq("rst_mem", {23'd0, mem_reqValid, mem_wen, mem_wmask, mem_size}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_idle_outs("rst");
    reset = 1'b1;
    tick();
    check_idle_outs("rel");

    // Spurious downstream responses in IDLE
    for (int k = 0; k < 4; k++) begin
      mem_respValid = 1'b1;
      mem_rdata = $urandom;
      tick();
      check_idle_outs("spur");
    end
    mem_respValid = 1'b0;

    // Contested grants straight after reset
    ifu_addr = 32'h0000_1000; ifu_reqValid = 1'b1;
    rand_lsu(); lsu_reqValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn($urandom_range(3, 0), $urandom, obs);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_lsu = (k % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      check_eq("both_grant", 32'(obs), 32'(exp_lsu));
      ifu_reqValid = 1'b1;
      if (!lsu_reqValid) begin rand_lsu(); lsu_reqValid = 1'b1; end
    end
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    mem_respValid = 1'b0;
    tick();
    check_idle_outs("drain");

    // Single IFU fetch
    ifu_addr = 32'h3000_0000; ifu_reqValid = 1'b1;
    run_txn(1, 32'h0010_0073, obs);
    check_eq("fetch_data", ifu_rdata, 32'h0010_0073);

    // LSU byte store
    lsu_addr = 32'h1000_0000; lsu_wen = 1'b1; lsu_wdata = 32'h41;
    lsu_wmask = 4'h1; lsu_size = 2'd0; lsu_reqValid = 1'b1;
    run_txn(2, 32'h0, obs);

    // LSU read to an unresponsive slave
    lsu_addr = 32'h2000_0004; lsu_wen = 1'b0; lsu_wmask = 4'hf; lsu_size = 2'd2;
    lsu_reqValid = 1'b1;
    run_txn(100, 32'h0, obs);
    check_eq("to_rdata", lsu_rdata, ERR);

    // Response and timeout coincide
    lsu_reqValid = 1'b1;
    run_txn(TO - 1, 32'h1234_5678, obs);

    // Reset during ISSUE, late downstream response dropped
    ifu_addr = 32'h3000_0040; ifu_reqValid = 1'b1;
    mem_respValid = 1'b0;
    tick();
    check_eq("mid_mreq", 32'(mem_reqValid), 32'd1);
    #2 reset = 1'b0;
    #1;
    m_rr = 1'b0; m_ifu_rd = '0; m_lsu_rd = '0;
    check_eq("mid_rst_mem", {23'd0, mem_reqValid, mem_wen, mem_wmask, mem_size}, 32'd0);
    check_eq("mid_rst_addr", mem_addr, 32'd0);
    check_idle_outs("mid_rst");
    tick();
    mem_respValid = 1'b1;
    tick();
    mem_respValid = 1'b0;
    ifu_reqValid = 1'b0;
    reset = 1'b1;
    tick();
    check_idle_outs("after_rst");
    tick();
    check_idle_outs("after_rst2");
    ifu_addr = 32'h3000_0080; ifu_reqValid = 1'b1;
    run_txn(3, 32'h0000_0013, obs);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if (!ifu_reqValid && $urandom_range(1, 0) == 1) begin
        ifu_addr = $urandom; ifu_reqValid = 1'b1;
      end
      if (!lsu_reqValid && $urandom_range(1, 0) == 1) begin
        rand_lsu(); lsu_reqValid = 1'b1;
      end
      if (ifu_reqValid || lsu_reqValid) run_txn($urandom_range(10, 0), $urandom, obs);
      else idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
